// File: rtl/finger_dancer_pkg.sv
// Shared grade codes, window state encodings and lane-index width helper.
package finger_dancer_pkg;

  typedef logic [1:0] grade_t;

  localparam grade_t GRADE_NONE    = 2'd0;
  localparam grade_t GRADE_PERFECT = 2'd1;
  localparam grade_t GRADE_GOOD    = 2'd2;
  localparam grade_t GRADE_MISS    = 2'd3;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_OPEN = 1'b1
  } win_state_t;

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_judge_ctrl_if.sv
// Result stream from the judge to score/display logic: valid/ready, lane index and grade.
interface lane_judge_ctrl_if #(
  parameter int LANES = 4
);
  import finger_dancer_pkg::*;

  localparam int LW = lane_w(LANES);

  logic          result_valid;
  logic          result_ready;
  logic [LW-1:0] result_lane;
  grade_t        result_grade;

  modport master (
    output result_valid,
    output result_lane,
    output result_grade,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_lane,
    input  result_grade,
    output result_ready
  );

endinterface

// File: rtl/lane_debounce.sv
// One lane: 2-FF synchroniser, DEB_CYCLES-sample debounce, 1-cycle pulse coincident with val rising.
// Latency: sw change -> val after 2 + DEB_CYCLES cycles; no backpressure.
module lane_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_val,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_val;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive synchronised samples that disagree with r_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_val   <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_val) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_cnt  <= '0;
        r_val  <= r_sync2;
        r_rise <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_val  = r_val;
  assign o_rise = r_rise;

endmodule

// File: rtl/lane_judge_ctrl.sv
// Per-lane hit windows graded into 1-deep slots, round-robin onto one valid/ready stream (1 cycle grade->present).
// Results held while !ready; full slot drops new grade and sets overrun. LANE_JUDGE_COMBO_EN adds combo/combo_max.
module lane_judge_ctrl
  import finger_dancer_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEB_CYCLES  = 16,
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [LANES-1:0] SW,
  input  logic [LANES-1:0] note_arrive,
  output logic [LANES-1:0] val,
  output logic [LANES-1:0] overrun,
`ifdef LANE_JUDGE_COMBO_EN
  output logic [7:0]       combo,
  output logic [7:0]       combo_max,
`endif
  lane_judge_ctrl_if.master res
);

  localparam int LW = lane_w(LANES);
  localparam int CW = $clog2(WIN_GOOD + 1);

  logic [LANES-1:0] w_rise;

  win_state_t       r_state [LANES];
  logic [CW-1:0]    r_cnt   [LANES];
  logic [LANES-1:0] r_slot_vld;
  grade_t           r_slot_grade [LANES];
  logic [LANES-1:0] r_overrun;
  logic             r_out_vld;
  logic [LW-1:0]    r_out_lane;
  grade_t           r_out_grade;
  logic [LW-1:0]    r_last;

  win_state_t       w_state_nxt [LANES];
  logic [CW-1:0]    w_cnt_nxt   [LANES];
  grade_t           w_grade     [LANES];
  logic             w_pop;
  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_drop;
  logic [LANES-1:0] w_slot_vld_nxt;
  grade_t           w_slot_grade_nxt [LANES];
  logic             w_gnt_vld;
  logic [LW-1:0]    w_gnt_lane;
  grade_t           w_gnt_grade;

  for (genvar g = 0; g < LANES; g++) begin : g_deb
    lane_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .i_sw   (SW[g]),
      .o_val  (val[g]),
      .o_rise (w_rise[g])
    );
  end

  // A note arriving on an open window retires the old note as MISS and swallows any same-cycle press.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_grade[i]     = GRADE_NONE;
      if (r_state[i] == W_IDLE) begin
        if (note_arrive[i]) begin
          w_state_nxt[i] = W_OPEN;
          w_cnt_nxt[i]   = '0;
        end
      end else if (note_arrive[i]) begin
        w_grade[i]   = GRADE_MISS;
        w_cnt_nxt[i] = '0;
      end else if (w_rise[i]) begin
        w_grade[i]     = (r_cnt[i] <= CW'(WIN_PERFECT)) ? GRADE_PERFECT : GRADE_GOOD;
        w_state_nxt[i] = W_IDLE;
      end else if (tick) begin
        if (r_cnt[i] == CW'(WIN_GOOD)) begin
          w_grade[i]     = GRADE_MISS;
          w_state_nxt[i] = W_IDLE;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Next slot contents include this cycle's pop and loads, so a fresh grade can be granted immediately.
  always_comb begin
    w_pop = r_out_vld & res.result_ready;
    for (int i = 0; i < LANES; i++) begin
      w_hit[i]            = w_pop && (r_out_lane == LW'(i));
      w_drop[i]           = 1'b0;
      w_slot_vld_nxt[i]   = r_slot_vld[i] & ~w_hit[i];
      w_slot_grade_nxt[i] = r_slot_grade[i];
      if (w_grade[i] != GRADE_NONE) begin
        if (!r_slot_vld[i] || w_hit[i]) begin
          w_slot_vld_nxt[i]   = 1'b1;
          w_slot_grade_nxt[i] = w_grade[i];
        end else begin
          w_drop[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin: lowest full lane above r_last, else lowest full lane overall.
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt_lane  = '0;
    w_gnt_grade = GRADE_NONE;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_slot_vld_nxt[i] && (LW'(i) > r_last)) begin
        w_gnt_vld   = 1'b1;
        w_gnt_lane  = LW'(i);
        w_gnt_grade = w_slot_grade_nxt[i];
      end
    end
    if (!w_gnt_vld) begin
      for (int i = LANES - 1; i >= 0; i--) begin
        if (w_slot_vld_nxt[i]) begin
          w_gnt_vld   = 1'b1;
          w_gnt_lane  = LW'(i);
          w_gnt_grade = w_slot_grade_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i]      <= W_IDLE;
        r_cnt[i]        <= '0;
        r_slot_grade[i] <= GRADE_NONE;
      end
      r_slot_vld  <= '0;
      r_overrun   <= '0;
      r_out_vld   <= 1'b0;
      r_out_lane  <= '0;
      r_out_grade <= GRADE_NONE;
      r_last      <= LW'(LANES - 1);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i]      <= w_state_nxt[i];
        r_cnt[i]        <= w_cnt_nxt[i];
        r_slot_grade[i] <= w_slot_grade_nxt[i];
      end
      r_slot_vld <= w_slot_vld_nxt;
      r_overrun  <= r_overrun | w_drop;
      if (!r_out_vld || w_pop) begin
        r_out_vld <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_out_lane  <= w_gnt_lane;
          r_out_grade <= w_gnt_grade;
          r_last      <= w_gnt_lane;
        end
      end
    end
  end

  assign res.result_valid = r_out_vld;
  assign res.result_lane  = r_out_lane;
  assign res.result_grade = r_out_grade;
  assign overrun          = r_overrun;

`ifdef LANE_JUDGE_COMBO_EN
  logic [7:0] r_combo;
  logic [7:0] r_combo_max;
  logic [7:0] w_combo_nxt;

  always_comb begin
    w_combo_nxt = r_combo;
    if (w_pop) begin
      if (r_out_grade == GRADE_MISS) begin
        w_combo_nxt = 8'd0;
      end else if (r_combo != 8'hFF) begin
        w_combo_nxt = r_combo + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_combo     <= 8'd0;
      r_combo_max <= 8'd0;
    end else begin
      r_combo <= w_combo_nxt;
      if (w_combo_nxt > r_combo_max) begin
        r_combo_max <= w_combo_nxt;
      end
    end
  end

  assign combo     = r_combo;
  assign combo_max = r_combo_max;
`endif

endmodule

// File: tb/tb_lane_judge_ctrl.sv
// Scoreboard bench for lane_judge_ctrl: expected results queued at stimulus, compared on each handshake.
module tb_lane_judge_ctrl;
  import finger_dancer_pkg::*;

  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [LANES-1:0] SW = '0;
  logic [LANES-1:0] note_arrive = '0;
  logic [LANES-1:0] val;
  logic [LANES-1:0] overrun;
`ifdef LANE_JUDGE_COMBO_EN
  logic [7:0]       combo;
  logic [7:0]       combo_max;
`endif

  lane_judge_ctrl_if #(.LANES(LANES)) res_if ();

  lane_judge_ctrl #(
    .LANES       (LANES),
    .DEB_CYCLES  (16),
    .WIN_PERFECT (2),
    .WIN_GOOD    (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .SW          (SW),
    .note_arrive (note_arrive),
    .val         (val),
    .overrun     (overrun),
`ifdef LANE_JUDGE_COMBO_EN
    .combo       (combo),
    .combo_max   (combo_max),
`endif
    .res         (res_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lane;
    grade_t     grade;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard side: every accepted handshake must match the oldest expected result.
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst && res_if.result_valid && res_if.result_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(res_if.result_valid), 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("sb_lane", 32'(res_if.result_lane), 32'(e_mon.lane));
        check("sb_grade", 32'(res_if.result_grade), 32'(e_mon.grade));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic note(input logic [LANES-1:0] m);
    note_arrive = m;
    cyc();
    note_arrive = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic push(input int lane, input grade_t g);
    exp_t e;
    e.lane  = 2'(lane);
    e.grade = g;
    sb.push_back(e);
  endtask

  task automatic wait_val(input int l, input logic lvl, input string tag);
    int k = 0;
    while (val[l] !== lvl && k < 60) begin
      cyc();
      k++;
    end
    check(tag, 32'(val[l]), 32'(lvl));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      cyc();
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int   rises;
  logic pv;

  initial begin
    res_if.result_ready = 1'b1;
    rst = 1'b1;
    cyc(3);
    check("rst_val", 32'(val), 32'd0);
    check("rst_valid", 32'(res_if.result_valid), 32'd0);
    check("rst_lane", 32'(res_if.result_lane), 32'd0);
    check("rst_grade", 32'(res_if.result_grade), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    cyc(2);

    // 1: press at cnt=1 -> PERFECT lane 0, presented one cycle after the grade cycle
    note(4'b0001);
    ticks(1);
    SW[0] = 1'b1;
    push(0, GRADE_PERFECT);
    wait_val(0, 1'b1, "t1_val_rise");
    cyc();
    check("t1_valid", 32'(res_if.result_valid), 32'd1);
    check("t1_lane", 32'(res_if.result_lane), 32'd0);
    check("t1_grade", 32'(res_if.result_grade), 32'(GRADE_PERFECT));
    drain("t1_drain");
    cyc(3);
    check("t1_single", 32'(res_if.result_valid), 32'd0);
    SW[0] = 1'b0;
    wait_val(0, 1'b0, "t1_val_fall");

    // 2: no press -> MISS on the 7th tick
    note(4'b0100);
    ticks(6);
    check("t2_no_early", 32'(res_if.result_valid), 32'd0);
    push(2, GRADE_MISS);
    ticks(1);
    check("t2_valid", 32'(res_if.result_valid), 32'd1);
    check("t2_lane", 32'(res_if.result_lane), 32'd2);
    check("t2_grade", 32'(res_if.result_grade), 32'(GRADE_MISS));
    drain("t2_drain");

    // 3: bouncing switch yields one debounced rise and one grade
    note(4'b0010);
    push(1, GRADE_PERFECT);
    rises = 0;
    pv = val[1];
    for (int c = 0; c < 40; c++) begin
      SW[1] = ((c / 3) % 2) == 0;
      cyc();
      if (val[1] && !pv) rises++;
      pv = val[1];
    end
    SW[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (val[1] && !pv) rises++;
      pv = val[1];
    end
    check("t3_rises", 32'(rises), 32'd1);
    drain("t3_drain");
    SW[1] = 1'b0;
    wait_val(1, 1'b0, "t3_val_fall");

    // 4: lanes 0,1,3 grade together under backpressure, then drain one per cycle
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    res_if.result_ready = 1'b0;
    note(4'b1011);
    ticks(6);
    push(0, GRADE_MISS);
    push(1, GRADE_MISS);
    push(3, GRADE_MISS);
    ticks(1);
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid", 32'(res_if.result_valid), 32'd1);
      check("t4_hold_lane", 32'(res_if.result_lane), 32'd0);
      check("t4_hold_grade", 32'(res_if.result_grade), 32'(GRADE_MISS));
      cyc();
    end
    res_if.result_ready = 1'b1;
    cyc();
    check("t4_second_lane", 32'(res_if.result_lane), 32'd1);
    cyc();
    check("t4_third_lane", 32'(res_if.result_lane), 32'd3);
    cyc();
    check("t4_empty", 32'(res_if.result_valid), 32'd0);
    check("t4_sb", 32'(sb.size()), 32'd0);

    // 5: full slot under backpressure drops the timeout and flags overrun
    res_if.result_ready = 1'b0;
    note(4'b0001);
    ticks(3);
    SW[0] = 1'b1;
    push(0, GRADE_GOOD);
    wait_val(0, 1'b1, "t5_val_rise");
    cyc();
    check("t5_first_grade", 32'(res_if.result_grade), 32'(GRADE_GOOD));
    check("t5_no_overrun", 32'(overrun), 32'd0);
    SW[0] = 1'b0;
    wait_val(0, 1'b0, "t5_val_fall");
    note(4'b0001);
    ticks(7);
    check("t5_overrun", 32'(overrun[0]), 32'd1);
    check("t5_kept_lane", 32'(res_if.result_lane), 32'd0);
    check("t5_kept_grade", 32'(res_if.result_grade), 32'(GRADE_GOOD));
    res_if.result_ready = 1'b1;
    drain("t5_drain");
    cyc(2);
    check("t5_dropped", 32'(res_if.result_valid), 32'd0);

    // 6: re-arrival retires old note as MISS; restarted window graded GOOD at cnt=4
    note(4'b0010);
    ticks(3);
    push(1, GRADE_MISS);
    note(4'b0010);
    drain("t6_miss_drain");
`ifdef LANE_JUDGE_COMBO_EN
    check("t6_combo_zero", 32'(combo), 32'd0);
`endif
    ticks(4);
    SW[1] = 1'b1;
    push(1, GRADE_GOOD);
    wait_val(1, 1'b1, "t6_val_rise");
    drain("t6_good_drain");
    cyc();
`ifdef LANE_JUDGE_COMBO_EN
    check("t6_combo_one", 32'(combo), 32'd1);
    check("t6_combo_max", 32'(combo_max), 32'd1);
`endif
    SW[1] = 1'b0;
    wait_val(1, 1'b0, "t6_val_fall");

    check("end_overrun", 32'(overrun), 32'h1);
    check("end_sb", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
